// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: compare the shifted partial remainder with the
// divisor and subtract when it fits.
module mdu_divstep
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic             quotBit
);

    logic [WIDTH:0] diff;

    // A clear top bit of the difference means no borrow, so the divisor fits.
    always_comb begin
        diff    = partial - {1'b0, divisor};
        quotBit = ~diff[WIDTH];
        remOut  = quotBit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-subtract
// step per cycle, with MTHI/MTLO moves accepted while idle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITER  = MDU_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWrite,
    input  logic             loWrite,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             stateReg, stateNext;
    logic [5:0]         countReg;
    logic [WIDTH-1:0]   srcAReg;
    logic [WIDTH-1:0]   operandReg;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] workReg;      // MUL: {acc, multiplier}; DIV: {rem, quot}
    logic               resNegReg;
    logic               remNegReg;

    logic               accept, lastStep, isSigned, aNeg, bNeg;
    logic [WIDTH-1:0]   magA, magB;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext, divNext, prodSigned;
    logic [WIDTH-1:0]   divRem, resultHi, resultLo;
    logic               divBit;

    mdu_divstep #(.WIDTH(WIDTH)) uDivStep (
        .partial (workReg[2*WIDTH-1:WIDTH-1]),
        .divisor (operandReg),
        .remOut  (divRem),
        .quotBit (divBit)
    );

    always_comb begin
        isSigned = (op == OP_MULT) || (op == OP_DIV);
        aNeg     = isSigned & srcA[WIDTH-1];
        bNeg     = isSigned & srcB[WIDTH-1];
        magA     = aNeg ? -srcA : srcA;
        magB     = bNeg ? -srcB : srcB;
    end

    always_comb begin
        mulSum     = {1'b0, workReg[2*WIDTH-1:WIDTH]}
                   + {1'b0, (workReg[0] ? operandReg : {WIDTH{1'b0}})};
        mulNext    = {mulSum, workReg[WIDTH-1:1]};
        divNext    = {divRem, workReg[WIDTH-2:0], divBit};
        prodSigned = resNegReg ? -mulNext : mulNext;
        resultHi   = prodSigned[2*WIDTH-1:WIDTH];
        resultLo   = prodSigned[WIDTH-1:0];
        if (stateReg == S_DIV) begin
            if (operandReg == '0) begin
                resultHi = srcAReg;
                resultLo = '1;
            end else begin
                resultHi = remNegReg ? -divNext[2*WIDTH-1:WIDTH] : divNext[2*WIDTH-1:WIDTH];
                resultLo = resNegReg ? -divNext[WIDTH-1:0] : divNext[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        lastStep  = (countReg == 6'(ITER - 1));
        case (stateReg)
            S_IDLE, S_DONE: begin
                done = (stateReg == S_DONE);
                if (start) begin
                    accept    = 1'b1;
                    stateNext = op[1] ? S_DIV : S_MUL;
                end else begin
                    stateNext = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (lastStep) stateNext = S_DONE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg   <= S_IDLE;
            countReg   <= '0;
            srcAReg    <= '0;
            operandReg <= '0;
            workReg    <= '0;
            resNegReg  <= 1'b0;
            remNegReg  <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            stateReg <= stateNext;
            if (accept) begin
                countReg  <= '0;
                srcAReg   <= srcA;
                resNegReg <= aNeg ^ bNeg;
                remNegReg <= aNeg;
                if (op[1]) begin
                    operandReg <= magB;
                    workReg    <= {{WIDTH{1'b0}}, magA};
                end else begin
                    operandReg <= magA;
                    workReg    <= {{WIDTH{1'b0}}, magB};
                end
            end else if (busy) begin
                countReg <= countReg + 6'd1;
                workReg  <= (stateReg == S_DIV) ? divNext : mulNext;
                if (lastStep) begin
                    hi <= resultHi;
                    lo <= resultLo;
                end
            end else begin
                if (hiWrite) hi <= srcA;
                if (loWrite) lo <= srcA;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against a transaction-level
// arithmetic model of HI/LO, busy and done.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA, srcB;
    logic        hiWrite, loWrite;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b1;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .hiWrite (hiWrite),
        .loWrite (loWrite),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {HI, LO}.
    function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        int              qa, qb;
        logic [63:0]     r;
        case (o)
            2'b00: r = 64'(sa * sb);
            2'b01: r = ua * ub;
            2'b10: begin
                if (b == 32'h0) r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
                else begin
                    qa = $signed(a);
                    qb = $signed(b);
                    r  = {32'(qa % qb), 32'(qa / qb)};
                end
            end
            default: begin
                if (b == 32'h0) r = {a, 32'hFFFFFFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Transaction-level model: an accepted op finishes 32 edges later.
    int          mBusyLeft;
    logic        mDone;
    logic [31:0] expHi, expLo;
    logic [63:0] pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusyLeft <= 0;
            mDone     <= 1'b0;
            expHi     <= '0;
            expLo     <= '0;
            pend      <= '0;
        end else begin
            mDone <= 1'b0;
            if (mBusyLeft > 0) begin
                mBusyLeft <= mBusyLeft - 1;
                if (mBusyLeft == 1) begin
                    expHi <= pend[63:32];
                    expLo <= pend[31:0];
                    mDone <= 1'b1;
                end
            end else if (start) begin
                pend      <= refResult(op, srcA, srcB);
                mBusyLeft <= 32;
            end else begin
                if (hiWrite) expHi <= srcA;
                if (loWrite) expLo <= srcA;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("busy", {31'b0, busy}, {31'b0, (mBusyLeft != 0)});
            check("done", {31'b0, done}, {31'b0, mDone});
            check("hi", hi, expHi);
            check("lo", lo, expLo);
        end
    end

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Waits for done (bounded) from the cycle after start was sampled.
    task automatic waitDone(input string name, output int n, output int busyCnt);
        n       = 1;
        busyCnt = busy ? 1 : 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) busyCnt++;
        end
        check({name, "_latency"}, 32'(n), 32'd33);
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo);
        int n, busyCnt;
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0;
        waitDone(name, n, busyCnt);
        check({name, "_busycycles"}, 32'(busyCnt), 32'd32);
        check({name, "_hi"}, hi, eHi);
        check({name, "_lo"}, lo, eLo);
        $display("op %s a=%h b=%h -> hi=%h lo=%h latency=%0d", name, a, b, hi, lo, n);
    endtask

    initial begin
        logic [63:0] m;
        int          n, busyCnt, doneSeen;

        reset = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
        hiWrite = 1'b0; loWrite = 1'b0;

        // Pin the model on hand-computed values.
        m = refResult(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("model_multu", m[31:0], 32'h00000001);
        m = refResult(2'b10, 32'hFFFFFFF9, 32'h2);
        check("model_div_hi", m[63:32], 32'hFFFFFFFF);
        m = refResult(2'b00, 32'hFFFFFFFD, 32'h5);
        check("model_mult_lo", m[31:0], 32'hFFFFFFF1);

        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        runOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        runOp("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        runOp("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("divu_7_2", 2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
        runOp("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        runOp("divu_by0", 2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);

        // MTHI/MTLO in idle.
        @(negedge clk);
        hiWrite = 1'b1; loWrite = 1'b1; srcA = 32'h12345678;
        @(negedge clk);
        hiWrite = 1'b0; loWrite = 1'b0;
        check("mthi", hi, 32'h12345678);
        check("mtlo", lo, 32'h12345678);

        // Start and MTHI while busy are ignored; start in DONE runs back-to-back.
        @(negedge clk);
        start = 1'b1; op = 2'b00; srcA = 32'd2; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; hiWrite = 1'b1; op = 2'b11; srcA = 32'd55; srcB = 32'd1;
        @(negedge clk);
        start = 1'b0; hiWrite = 1'b0;
        n = 6;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("busy_ign_latency", 32'(n), 32'd33);
        check("busy_ign_hi", hi, 32'd0);
        check("busy_ign_lo", lo, 32'd6);
        $display("op busy_ignore 2*3 -> hi=%h lo=%h", hi, lo);
        start = 1'b1; op = 2'b01; srcA = 32'd7; srcB = 32'd8;
        @(negedge clk);
        start = 1'b0;
        waitDone("b2b", n, busyCnt);
        check("b2b_lo", lo, 32'd56);
        $display("op back_to_back 7*8 -> hi=%h lo=%h latency=%0d", hi, lo, n);

        // Reset mid-operation aborts immediately.
        @(negedge clk);
        start = 1'b1; op = 2'b10; srcA = 32'd100; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        check("abort_no_done", 32'(doneSeen), 32'd0);
        $display("op reset_abort -> busy=%b hi=%h lo=%h done_pulses=%0d", busy, hi, lo, doneSeen);

        // Random traffic checked cycle by cycle against the model.
        repeat (3000) begin
            @(negedge clk);
            start   = ($urandom_range(0, 9) < 4);
            hiWrite = ($urandom_range(0, 3) == 0);
            loWrite = ($urandom_range(0, 3) == 0);
            op      = 2'($urandom);
            srcA    = randOperand();
            srcB    = randOperand();
            if (done) $display("txn done hi=%h lo=%h", hi, lo);
        end
        @(negedge clk);
        start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
        repeat (40) @(negedge clk);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter ITER, default 32, iteration cycles per operation.
REQ-003 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  launch operation; sampled at posedge.
REQ-007 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-008 srcA  input  32  rs operand, driven from register-file readData1.
REQ-009 srcB  input  32  rt operand, driven from register-file readData2.
REQ-010 hiWrite  input  1  MTHI: HI <= srcA.
REQ-011 loWrite  input  1  MTLO: LO <= srcA.
REQ-012 busy  output  1  operation in progress; CPU stalls on it.
REQ-013 done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-014 hi  output  32  HI register (MFHI source).
REQ-015 lo  output  32  LO register (MFLO source).

Function
REQ-016 FSM states IDLE, MUL, DIV, DONE; busy=1 only in MUL/DIV; done=1 only in DONE.
REQ-017 IDLE or DONE with start=1: latch operands/op, clear 6-bit counter, go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-018 MUL/DIV: one shift-add or restoring-subtract step per cycle; after ITER steps go to DONE, writing hi/lo on that same edge.
REQ-019 DONE without start: go to IDLE; DONE with start: accept a new operation (back-to-back).
REQ-020 Latency: start sampled at edge k -> done high and hi/lo valid during cycle k+33.
REQ-021 start, hiWrite, loWrite while busy=1: ignored, no state change.
REQ-022 hiWrite/loWrite in IDLE/DONE: HI/LO updated at the next edge; if start is also high, start wins and the moves are dropped.
REQ-023 Signed ops run on magnitudes; product negated if operand signs differ; quotient negative if signs differ; remainder takes the dividend's sign.
REQ-024 Product is the full 64-bit result: HI = bits 63:32, LO = bits 31:0.
REQ-025 Division: LO = quotient, HI = remainder (truncation toward zero).
REQ-026 Divide by zero (DIV or DIVU): full latency; LO = 32'hFFFFFFFF, HI = srcA.
REQ-027 DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
REQ-028 hi/lo hold their value through MUL/DIV until the DONE edge; intermediates live in internal registers.

Reset
REQ-029 reset=1: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, internal registers 0, asynchronously.
REQ-030 reset during MUL/DIV aborts the operation; no done pulse follows.

Structure
REQ-031 Package mdu_pkg holds the op encodings, FSM state encoding, ITER, and WIDTH.
REQ-032 One sub-module mdu_divstep: a combinational single restoring-divide step (remainder, divisor -> next remainder, quotient bit).

Verification
REQ-033 MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; done exactly 33 cycles after start; busy high for 32 cycles.
REQ-034 MULT FFFFFFFD(-3)*00000005 -> hi=FFFFFFFF, lo=FFFFFFF1.
REQ-035 DIV FFFFFFF9(-7)/00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 00000007/00000002 -> lo=3, hi=1.
REQ-036 DIVU 7/0 -> lo=FFFFFFFF, hi=7; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-037 start MULT 2*3, then start and hiWrite (srcA=55) at cycle 5 -> ignored; result hi=0, lo=6; a start issued in the DONE cycle runs back-to-back.
REQ-038 Start DIV, assert reset at cycle 10 -> busy, hi, lo = 0 immediately; no done pulse within the next 40 cycles.
